// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: one log-shifter stage per amount bit, global stall, sticky lost flag.
// Latency SHW register stages; any stall freezes the whole pipe and drops in_ready.
module barrel_shifter_pipe #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_lost
);

  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

  logic             vld_q  [0:SHW-1];
  logic [WIDTH-1:0] dat_q  [0:SHW-1];
  logic [SHW-1:0]   amt_q  [0:SHW-1];
  logic [1:0]       mode_q [0:SHW-1];
  logic             lost_q [0:SHW-1];

  // {lost, data} produced by each stage's shifter
  logic [WIDTH:0]   nxt    [0:SHW-1];

  logic en;

  // One conditional shift by s; lost accumulates the bits pushed off the word.
  function automatic logic [WIDTH:0] shift_stage(
    input logic [WIDTH-1:0] d,
    input logic             l,
    input logic             bit_set,
    input logic [1:0]       m,
    input int               s
  );
    logic [WIDTH-1:0] r;
    logic             x;
    r = d;
    x = l;
    if (bit_set) begin
      case (m)
        MODE_LSL: begin
          r = d << s;
          x = l | (|(d & ~(ONES >> s)));
        end
        MODE_LSR: begin
          r = d >> s;
          x = l | (|(d & ~(ONES << s)));
        end
        MODE_ASR: begin
          // MSB is still the operand sign in every stage, so it is the fill value
          r = $signed(d) >>> s;
          x = l | (|(d & ~(ONES << s)));
        end
        MODE_ROL: begin
          r = (d << s) | (d >> (WIDTH - s));
        end
        default: begin
          r = d;
        end
      endcase
    end
    return {x, r};
  endfunction

  assign out_valid = vld_q[SHW-1];
  assign out_data  = dat_q[SHW-1];
  assign out_lost  = lost_q[SHW-1];
  assign en        = !out_valid || out_ready;
  assign in_ready  = en;

  always_comb begin
    nxt[0] = shift_stage(in_data, 1'b0, in_amt[0], in_mode, 1);
    for (int k = 1; k < SHW; k++) begin
      nxt[k] = shift_stage(dat_q[k-1], lost_q[k-1], amt_q[k-1][k], mode_q[k-1], 1 << k);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SHW; k++) begin
        vld_q[k]  <= 1'b0;
        dat_q[k]  <= '0;
        amt_q[k]  <= '0;
        mode_q[k] <= '0;
        lost_q[k] <= 1'b0;
      end
    end else if (en) begin
      // an idle input cycle loads a bubble, which keeps result timing fixed
      vld_q[0]  <= in_valid;
      dat_q[0]  <= nxt[0][WIDTH-1:0];
      lost_q[0] <= nxt[0][WIDTH];
      amt_q[0]  <= in_amt;
      mode_q[0] <= in_mode;
      for (int k = 1; k < SHW; k++) begin
        vld_q[k]  <= vld_q[k-1];
        dat_q[k]  <= nxt[k][WIDTH-1:0];
        lost_q[k] <= nxt[k][WIDTH];
        amt_q[k]  <= amt_q[k-1];
        mode_q[k] <= mode_q[k-1];
      end
    end
  end

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Bench for barrel_shifter_pipe at WIDTH 8: directed mode table, latency, back-pressure, bubbles, reset, random.
module tb_barrel_shifter_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_amt;
  logic [1:0] in_mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_lost;

  barrel_shifter_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_lost  (out_lost)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] res;
    int         acc;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  bit         acc_hist [0:16383];
  bit         timing_on = 1'b0;
  bit         lat_on = 1'b0;
  bit         stalled_prev = 1'b0;
  logic [8:0] held;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference result {lost, data} from the shift definitions, computed on plain integers.
  function automatic logic [8:0] ref_shift(input logic [7:0] d, input logic [2:0] a, input logic [1:0] m);
    int t;
    int sv;
    int r;
    bit l;
    l = 1'b0;
    r = d;
    case (m)
      2'd0: begin t = int'(d) << a; r = t & 255; l = (t >> 8) != 0; end
      2'd1: begin r = int'(d) >> a; l = (int'(d) % (1 << a)) != 0; end
      2'd2: begin
        sv = d[7] ? int'(d) - 256 : int'(d);
        r  = (sv >>> a) & 255;
        l  = (int'(d) % (1 << a)) != 0;
      end
      default: begin r = ((int'(d) << a) | (int'(d) >> (8 - a))) & 255; l = 1'b0; end
    endcase
    return {l, r[7:0]};
  endfunction

  // One clock cycle: drive, check outputs against the scoreboard, record acceptance.
  task automatic cycle(input logic iv, input logic [7:0] id, input logic [2:0] ia,
                       input logic [1:0] im, input logic ordy, input logic [8:0] ex,
                       output logic accepted);
    exp_t e;
    @(negedge clk);
    in_valid  = iv;
    in_data   = id;
    in_amt    = ia;
    in_mode   = im;
    out_ready = ordy;
    #1;
    if (stalled_prev) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", {out_lost, out_data}, held);
    end
    if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
    else                         chk("in_ready", in_ready, 1);
    if (timing_on && cyc >= 3) chk("valid_timing", out_valid, acc_hist[cyc-3]);
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("spurious_out", out_valid, 0);
      end else begin
        e = q.pop_front();
        chk("result", {out_lost, out_data}, e.res);
        if (lat_on) chk("latency", cyc - e.acc, 3);
      end
    end
    accepted = iv && in_ready;
    acc_hist[cyc] = accepted;
    if (accepted) q.push_back('{res: ex, acc: cyc});
    stalled_prev = out_valid && !out_ready;
    held = {out_lost, out_data};
    @(posedge clk);
    cyc++;
  endtask

  initial begin
    logic       a;
    logic [7:0] d;
    logic [2:0] am;
    logic [1:0] md;
    int         idx;
    int         n;
    int         guard;
    logic [7:0] bp_d [0:5];
    logic [2:0] bp_a [0:5];
    logic [1:0] bp_m [0:5];

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_amt = '0; in_mode = '0; out_ready = 1'b1;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_lost", out_lost, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed mode table, back to back
    timing_on = 1'b1;
    cycle(1, 8'd16,  3'd3, 2'd0, 1, {1'b0, 8'd128}, a);
    cycle(1, 8'd16,  3'd4, 2'd0, 1, {1'b1, 8'd0},   a);
    cycle(1, 8'd128, 3'd2, 2'd2, 1, {1'b0, 8'hE0},  a);
    cycle(1, 8'h96,  3'd3, 2'd1, 1, {1'b1, 8'h12},  a);
    cycle(1, 8'h81,  3'd1, 2'd3, 1, {1'b0, 8'h03},  a);
    for (int m = 0; m < 4; m++) cycle(1, 8'h5A, 3'd0, m[1:0], 1, {1'b0, 8'h5A}, a);
    for (int i = 0; i < 4; i++) cycle(0, 8'h00, 3'd0, 2'd0, 1, 9'h0, a);

    // Latency and throughput
    lat_on = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom); am = 3'($urandom); md = 2'($urandom);
      cycle(1, d, am, md, 1, ref_shift(d, am, md), a);
    end
    for (int i = 0; i < 4; i++) cycle(0, 8'h00, 3'd0, 2'd0, 1, 9'h0, a);
    chk("lat_drained", q.size(), 0);

    // Bubbles
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom); am = 3'($urandom); md = 2'($urandom);
      cycle(i[0] == 1'b0, d, am, md, 1, ref_shift(d, am, md), a);
    end
    for (int i = 0; i < 4; i++) cycle(0, 8'h00, 3'd0, 2'd0, 1, 9'h0, a);
    lat_on = 1'b0;
    timing_on = 1'b0;

    // Back-pressure: stream 6 operands with the consumer stalled
    for (int i = 0; i < 6; i++) begin
      bp_d[i] = 8'($urandom); bp_a[i] = 3'($urandom); bp_m[i] = 2'($urandom);
    end
    idx = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(idx < 6, bp_d[idx % 6], bp_a[idx % 6], bp_m[idx % 6], 0,
            ref_shift(bp_d[idx % 6], bp_a[idx % 6], bp_m[idx % 6]), a);
      if (a) idx++;
    end
    chk("bp_accepted", idx, 3);
    guard = 0;
    while ((idx < 6 || q.size() != 0) && guard < 40) begin
      cycle(idx < 6, bp_d[idx % 6], bp_a[idx % 6], bp_m[idx % 6], 1,
            ref_shift(bp_d[idx % 6], bp_a[idx % 6], bp_m[idx % 6]), a);
      if (a) idx++;
      guard++;
    end
    chk("bp_drained", q.size(), 0);
    chk("bp_all_issued", idx, 6);

    // Reset asserted with three operands in flight
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom | 1); am = 3'($urandom); md = 2'd3;
      cycle(1, d, am, md, 1, ref_shift(d, am, md), a);
    end
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    q.delete();
    stalled_prev = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) cycle(0, 8'h00, 3'd0, 2'd0, 1, 9'h0, a);

    // Random traffic with random back-pressure
    n = 0;
    guard = 0;
    d = 8'($urandom); am = 3'($urandom); md = 2'($urandom);
    while (n < 1000 && guard < 20000) begin
      cycle($urandom_range(0, 3) != 0, d, am, md, $urandom_range(0, 2) != 0,
            ref_shift(d, am, md), a);
      if (a) begin
        n++;
        d = 8'($urandom); am = 3'($urandom); md = 2'($urandom);
      end
      guard++;
    end
    chk("rand_issued", n, 1000);
    guard = 0;
    while (q.size() != 0 && guard < 50) begin
      cycle(0, 8'h00, 3'd0, 2'd0, 1, 9'h0, a);
      guard++;
    end
    chk("rand_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/barrel_shifter_pipe.md
# barrel_shifter_pipe

Parametrised, pipelined successor to the team's 8-bit combinational barrel shifter. Accepts one operand per cycle over a valid/ready handshake. Applies one of four shift modes (logical left, logical right, arithmetic right, rotate left) by a run-time amount, using one registered log-shifter stage per amount bit. Sits between an operand producer and a result consumer that may apply back-pressure; returns the shifted word plus a flag marking whether any set bit was discarded.

## Interface

Parameters:
- WIDTH, 8, data width in bits; power of two, ≥ 2.
- SHW, $clog2(WIDTH), shift-amount width and pipeline depth; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand present.
- in_ready  output  1  block accepts an operand this cycle.
- in_data  input  WIDTH  operand.
- in_amt  input  SHW  shift amount, 0..WIDTH-1.
- in_mode  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROL.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  shifted result.
- out_lost  output  1  at least one 1-bit was shifted out (always 0 for ROL).

## Operation

- Transfer on the input occurs when in_valid && in_ready. Transfer on the output occurs when out_valid && out_ready.
- Pipeline: SHW register stages. Stage k (k = 0..SHW-1) shifts by 2^k when amt bit k is set, otherwise passes through.
  - Each stage registers valid, data, remaining amt bits, mode and a sticky lost bit.
  - Stage SHW-1 drives the out_* ports directly.
- Fill rules:
  - LSL and LSR fill vacated positions with 0.
  - ASR fills with the operand MSB (in_data[WIDTH-1]).
  - ROL wraps the bits leaving the MSB into the LSB.
- Lost flag:
  - Per stage, OR of the bits discarded by that stage's shift: top 2^k bits for LSL, bottom 2^k bits for LSR/ASR, nothing for ROL.
  - The flag is accumulated (ORed) across stages.
- Amount 0 gives out_data = in_data and out_lost = 0 in every mode.
- Mode and amount are captured with the data. Changes on the input ports never affect operands already in flight.
- Global stall: the advance enable is en = !out_valid || out_ready.
  - All stages shift forward together when en = 1 and hold when en = 0.
  - in_ready = en, purely combinational from out_valid and out_ready.
  - Bubbles are not collapsed.
- While en = 1 and no input transfer occurs, a zero-valid bubble enters stage 0.

## Timing

- Reset (rst_n low, asynchronous): every stage valid = 0, data = 0, lost = 0. Hence out_valid = 0, out_data = 0, out_lost = 0 and in_ready = 1. All in-flight operands are discarded.
- Release of reset is sampled synchronously. The first transfer is possible on the first rising edge with rst_n high.
- Latency: an operand accepted at edge N appears with out_valid = 1 after edge N+SHW-1, provided no stall occurs. For WIDTH = 8 the result is visible 3 cycles after acceptance.
- Throughput: one result per cycle while out_ready = 1.
- Stall: out_valid = 1 with out_ready = 0 forces in_ready = 0 in the same cycle. All out_* signals hold stable until the transfer completes.
- Simultaneous input and output transfer in one cycle is legal; every stage advances.
- in_valid low while in_ready is high inserts a bubble. out_valid drops SHW cycles later for one cycle.
- Reset asserted mid-stream clears outputs immediately, without waiting for a clock edge. No partial result is ever presented.

## Test plan

All scenarios use WIDTH = 8.

- Reset: assert rst_n low mid-stream with 3 operands in flight → out_valid = 0, out_data = 0 and in_ready = 1 immediately. Nothing emerges after release.
- Modes, with out_ready held 1:
  - 16 LSL 3 → 128, lost 0.
  - 16 LSL 4 → 0, lost 1.
  - 128 ASR 2 → 0xE0, lost 0.
  - 0x96 LSR 3 → 0x12, lost 1.
  - 0x81 ROL 1 → 0x03, lost 0.
  - 0x5A with amount 0 in all 4 modes → 0x5A, lost 0.
- Latency and throughput: issue 8 back-to-back operands with out_ready = 1 → the first result appears 3 cycles after acceptance, then one result per cycle in issue order.
- Back-pressure: stream 6 operands while out_ready is held 0 → in_ready falls once the first result reaches the output, and out_data stays stable. Releasing out_ready drains all operands in order with no loss or duplication.
- Bubbles: alternate in_valid 1/0 → results emerge alternating out_valid 1/0, with correct values.
- Random: 1000 random (data, amt, mode) with random out_ready → every result and lost flag matches a reference model, in order.
